scan_seq_ctrl: RTL and testbench

//  Scan-access sequencer for the incr/decr unit. Takes one host scan request,

---
 rtl/scan_seq_pkg.sv | 17 +
 rtl/scan_shift_reg.sv | 28 ++
 rtl/scan_seq_ctrl.sv | 126 ++++++++++++
 tb/tb_scan_seq_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/scan_seq_pkg.sv
// Shared definitions for the scan-access sequencer: FSM state encoding and
// request mode constants.
package scan_seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_DRAIN = 3'd1;
  localparam state_t ST_SETUP = 3'd2;
  localparam state_t ST_SHIFT = 3'd3;
  localparam state_t ST_EXIT  = 3'd4;
  localparam state_t ST_RESP  = 3'd5;

  localparam logic MODE_DUMP = 1'b0;
  localparam logic MODE_LOAD = 1'b1;

endpackage

// File: rtl/scan_shift_reg.sv
// Capture register for the scan snapshot: cleared on request accept, one bit
// written per shift cycle at the given index, held otherwise.
module scan_shift_reg #(
  parameter int W  = 16,
  parameter int IW = $clog2(W)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          we_i,
  input  logic [IW-1:0] idx_i,
  input  logic          bit_i,
  output logic [W-1:0]  data_o
);

  logic [W-1:0] data_q;

  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      data_q <= '0;
    end else if (we_i) begin
      data_q[idx_i] <= bit_i;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/scan_seq_ctrl.sv
// Scan-access sequencer: drains the in-flight DUT op, shifts the scan chain
// CHAIN_LEN times (DUMP recirculates, LOAD drives a pattern) and returns sout.
// Handshakes: a transfer happens on the rising edge where valid & ready are
// both 1; req side is ready only in IDLE, resp_val holds with stable data
// until resp_rdy.
module scan_seq_ctrl
  import scan_seq_pkg::*;
#(
  parameter int CHAIN_LEN     = 16,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_val,
  output logic                 req_rdy,
  input  logic                 req_mode,
  input  logic [CHAIN_LEN-1:0] req_data,
  output logic                 resp_val,
  input  logic                 resp_rdy,
  output logic [CHAIN_LEN-1:0] resp_data,
  output logic                 resp_err,
  input  logic                 dut_busy,
  output logic                 hold_op,
  output logic                 sen,
  output logic                 scan_ce,
  output logic                 sin,
  input  logic                 sout,
  output logic [2:0]           dbg_state
);

  localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
  localparam int KW = $clog2(CHAIN_LEN);

  state_t               state_q, state_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [KW-1:0]        kcnt_q, kcnt_d;
  logic                 mode_q, mode_d;
  logic [CHAIN_LEN-1:0] data_q, data_d;
  logic                 err_q, err_d;
  logic                 accept;
  logic                 drain_to;

  assign accept   = (state_q == ST_IDLE) && req_val;
  assign drain_to = (state_q == ST_DRAIN) && dut_busy &&
                    (tcnt_q == TW'(DRAIN_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tcnt_q  <= '0;
      kcnt_q  <= '0;
      mode_q  <= MODE_DUMP;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      kcnt_q  <= kcnt_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (req_val) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!dut_busy)     state_d = ST_SETUP;
        else if (drain_to) state_d = ST_RESP;
      end
      ST_SETUP: state_d = ST_SHIFT;
      ST_SHIFT: if (kcnt_q == KW'(CHAIN_LEN - 1)) state_d = ST_EXIT;
      ST_EXIT:  state_d = ST_RESP;
      ST_RESP:  if (resp_rdy) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Timeout counter restarts on every DRAIN entry and saturates; shift index
  // restarts in SETUP and stops at the last bit.
  always_comb begin
    tcnt_d = tcnt_q;
    kcnt_d = kcnt_q;
    mode_d = mode_q;
    data_d = data_q;
    err_d  = err_q;
    if (state_q == ST_IDLE) tcnt_d = '0;
    if ((state_q == ST_DRAIN) && dut_busy && (tcnt_q != TW'(DRAIN_TIMEOUT)))
      tcnt_d = tcnt_q + 1'b1;
    if (state_q == ST_SETUP) kcnt_d = '0;
    if ((state_q == ST_SHIFT) && (kcnt_q != KW'(CHAIN_LEN - 1)))
      kcnt_d = kcnt_q + 1'b1;
    if (accept) begin
      mode_d = req_mode;
      data_d = req_data;
      err_d  = 1'b0;
    end
    if (drain_to) err_d = 1'b1;
  end

  always_comb begin
    req_rdy   = (state_q == ST_IDLE);
    hold_op   = (state_q != ST_IDLE);
    sen       = (state_q == ST_SETUP) || (state_q == ST_SHIFT);
    scan_ce   = (state_q == ST_SHIFT);
    resp_val  = (state_q == ST_RESP);
    resp_err  = err_q;
    dbg_state = state_q;
    sin       = 1'b0;
    if (state_q == ST_SHIFT)
      sin = (mode_q == MODE_LOAD) ? data_q[kcnt_q] : sout;
  end

  scan_shift_reg #(.W(CHAIN_LEN), .IW(KW)) u_capture (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (accept),
    .we_i   (state_q == ST_SHIFT),
    .idx_i  (kcnt_q),
    .bit_i  (sout),
    .data_o (resp_data)
  );

endmodule

// File: tb/tb_scan_seq_ctrl.sv
// Bench for scan_seq_ctrl: models the DUT scan chain as an 8-bit shift register
// and checks directed and randomized scan requests against a transaction model.
module tb_scan_seq_ctrl;

  localparam int CL = 8;
  localparam int DT = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_val = 1'b0;
  logic          req_rdy;
  logic          req_mode = 1'b0;
  logic [CL-1:0] req_data = '0;
  logic          resp_val;
  logic          resp_rdy = 1'b0;
  logic [CL-1:0] resp_data;
  logic          resp_err;
  logic          dut_busy = 1'b0;
  logic          hold_op;
  logic          sen;
  logic          scan_ce;
  logic          sin;
  logic          sout;
  logic [2:0]    dbg_state;

  int total = 0;
  int bad = 0;
  int rule_viol = 0;
  logic [CL-1:0] exp_q[$];

  scan_seq_ctrl #(.CHAIN_LEN(CL), .DRAIN_TIMEOUT(DT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_val   (req_val),
    .req_rdy   (req_rdy),
    .req_mode  (req_mode),
    .req_data  (req_data),
    .resp_val  (resp_val),
    .resp_rdy  (resp_rdy),
    .resp_data (resp_data),
    .resp_err  (resp_err),
    .dut_busy  (dut_busy),
    .hold_op   (hold_op),
    .sen       (sen),
    .scan_ce   (scan_ce),
    .sin       (sin),
    .sout      (sout),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // DUT scan chain model: sin enters bit 7, sout is bit 0
  logic [CL-1:0] chain = '0;
  logic [CL-1:0] chain_init = '0;
  logic          chain_load = 1'b0;

  always @(posedge clk) begin
    if (chain_load)   chain <= chain_init;
    else if (scan_ce) chain <= {sin, chain[CL-1:1]};
  end
  assign sout = chain[0];

  always @(negedge clk) begin
    if (scan_ce && !sen) rule_viol++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks (all start and end at a negedge)
  task automatic set_chain(input logic [CL-1:0] v);
    chain_init = v;
    chain_load = 1'b1;
    @(negedge clk);
    chain_load = 1'b0;
  endtask

  task automatic run_scan(input logic mode, input logic [CL-1:0] data, input int busy_n,
                          input int rdy_dly, input logic stray);
    logic [CL-1:0] chain0, exp_chain, exp_resp;
    logic          timeout;
    int            exp_lat, cyc, sen_n, ce_n, hold_bad, rdy_bad, stable_bad;
    chain0    = chain;
    timeout   = (busy_n >= DT);
    exp_chain = (timeout || mode == 1'b0) ? chain0 : data;
    exp_lat   = timeout ? DT + 1 : CL + 4 + busy_n;
    exp_q.push_back(timeout ? '0 : chain0);
    sen_n = 0; ce_n = 0; hold_bad = 0; rdy_bad = 0; stable_bad = 0;

    check_eq("req_rdy_idle", req_rdy, 1);
    req_val  = 1'b1;
    req_mode = mode;
    req_data = data;
    @(negedge clk);
    cyc = 1;
    req_val = 1'b0;
    while (!resp_val && cyc < 40) begin
      if (!hold_op) hold_bad++;
      if (sen) sen_n++;
      if (scan_ce) ce_n++;
      if (req_rdy) rdy_bad++;
      dut_busy = (cyc <= busy_n);
      if (stray) begin
        req_val  = 1'($urandom_range(0, 1));
        req_data = CL'($urandom);
        req_mode = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      cyc++;
    end
    dut_busy = 1'b0;
    check_eq("latency", cyc, exp_lat);
    check_eq("resp_val_seen", resp_val, 1);

    exp_resp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    for (int i = 0; i < rdy_dly; i++) begin
      if (resp_val !== 1'b1 || resp_data !== exp_resp || req_rdy !== 1'b0 || !hold_op)
        stable_bad++;
      @(negedge clk);
    end
    check_eq("resp_data", resp_data, exp_resp);
    check_eq("resp_err", resp_err, timeout);
    check_eq("resp_stable", stable_bad, 0);
    req_val  = 1'b0;
    resp_rdy = 1'b1;
    @(negedge clk);
    resp_rdy = 1'b0;
    check_eq("resp_pulse_end", resp_val, 0);
    check_eq("hold_op_release", hold_op, 0);
    check_eq("req_rdy_back", req_rdy, 1);
    check_eq("chain_after", chain, exp_chain);
    check_eq("sen_cycles", sen_n, timeout ? 0 : CL + 1);
    check_eq("ce_cycles", ce_n, timeout ? 0 : CL);
    check_eq("hold_op_busy", hold_bad, 0);
    check_eq("req_rdy_busy", rdy_bad, 0);
  endtask

  task automatic run_reset_mid_shift();
    int cyc;
    int rv;
    set_chain(8'h5A);
    req_val  = 1'b1;
    req_mode = 1'b1;
    req_data = 8'hC3;
    @(negedge clk);
    req_val = 1'b0;
    cyc = 1;
    // accept at cycle 0, SHIFT k=0 is cycle 3, so k=3 is cycle 6
    while (cyc < 6) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("mid_shift_ce", scan_ce, 1);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rst_sen", sen, 0);
    check_eq("rst_scan_ce", scan_ce, 0);
    check_eq("rst_hold_op", hold_op, 0);
    check_eq("rst_resp_val", resp_val, 0);
    reset = 1'b0;
    rv = 0;
    for (int i = 0; i < 20; i++) begin
      if (resp_val) rv++;
      @(negedge clk);
    end
    check_eq("rst_no_resp", rv, 0);
    check_eq("rst_req_rdy", req_rdy, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_eq("reset_req_rdy", req_rdy, 1);
    check_eq("reset_resp_val", resp_val, 0);
    check_eq("reset_resp_err", resp_err, 0);
    check_eq("reset_resp_data", resp_data, 0);
    check_eq("reset_hold_op", hold_op, 0);
    check_eq("reset_sen", sen, 0);
    check_eq("reset_scan_ce", scan_ce, 0);
    check_eq("reset_sin", sin, 0);

    set_chain(8'hA5);
    run_scan(1'b0, 8'h00, 0, 0, 1'b0);
    set_chain(8'hFF);
    run_scan(1'b1, 8'h3C, 0, 0, 1'b0);
    run_scan(1'b0, 8'h00, 3, 1, 1'b0);
    run_scan(1'b1, 8'h96, 100, 0, 1'b0);
    set_chain(8'h81);
    run_scan(1'b1, 8'h7E, 0, 5, 1'b1);
    run_reset_mid_shift();

    for (int n = 0; n < 24; n++) begin
      set_chain(CL'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_scan(1'($urandom_range(0, 1)), CL'($urandom), $urandom_range(0, 5),
               $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    check_eq("queue_empty", exp_q.size(), 0);
    check_eq("ce_without_sen", rule_viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
